// File: rtl/glip_cypressfx2_fx2_model_if.sv
// glip_cypressfx2_fx2_model_if: FX2 slave-FIFO pin bundle between FPGA-side logic (master) and chip model (slave).
interface glip_cypressfx2_fx2_model_if;
  logic [15:0] fx2_fd_in;
  logic [15:0] fx2_fd_out;
  logic        fx2_fd_oe;
  logic        fx2_sloe_n;
  logic        fx2_slrd_n;
  logic        fx2_slwr_n;
  logic        fx2_pktend_n;
  logic [1:0]  fx2_fifoadr;
  logic        fx2_flaga_n;
  logic        fx2_flagb_n;
  logic        fx2_flagc_n;
  logic        fx2_flagd_n;
  modport master (
    output fx2_fd_in, fx2_sloe_n, fx2_slrd_n, fx2_slwr_n, fx2_pktend_n, fx2_fifoadr,
    input  fx2_fd_out, fx2_fd_oe, fx2_flaga_n, fx2_flagb_n, fx2_flagc_n, fx2_flagd_n
  );
  modport slave (
    input  fx2_fd_in, fx2_sloe_n, fx2_slrd_n, fx2_slwr_n, fx2_pktend_n, fx2_fifoadr,
    output fx2_fd_out, fx2_fd_oe, fx2_flaga_n, fx2_flagb_n, fx2_flagc_n, fx2_flagd_n
  );
endinterface

// File: rtl/glip_cypressfx2_fx2_model.sv
// glip_cypressfx2_fx2_model: FX2 chip-side slave-FIFO emulator with EP2 OUT / EP6 IN buffers and host streaming ports.
// Define GLIP_FX2_MODEL_FLAG_DLY_EN to delay all four flags by one register stage like real silicon.
module glip_cypressfx2_fx2_model #(
  parameter int DEPTH         = 512,
  parameter int PKT_WORDS     = 256,
  parameter int AFULL_THRESH  = 4,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic        fx2_ifclk,
  input  logic        fx2_rst_n,
  glip_cypressfx2_fx2_model_if.slave fx2,
  input  logic        host_out_valid,
  output logic        host_out_ready,
  input  logic [15:0] host_out_data,
  output logic        host_in_valid,
  input  logic        host_in_ready,
  output logic [15:0] host_in_data,
  output logic        host_in_last,
  output logic [2:0]  err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [15:0]   ep2_mem [DEPTH];
  logic [AW-1:0] ep2_wp, ep2_rp;
  logic [CW-1:0] ep2_cnt;

  logic [15:0]   ep6_mem  [DEPTH];
  logic          ep6_last [DEPTH];
  logic [AW-1:0] ep6_wp, ep6_rp;
  logic [CW-1:0] ep6_pend, ep6_comm;

  logic          sel_ep2, sel_ep6, any_strobe, conflict;
  logic          ep2_push, ep2_pop, ep2_under;
  logic          ep6_wr, ep6_push, ep6_over, ep6_pop, ep6_end;
  logic          commit_pkt, commit_end, commit;
  logic [CW-1:0] ep6_occ, ep6_free, pend_inc;
  logic [3:0]    flags_c;

  always_comb begin
    sel_ep2    = fx2.fx2_fifoadr == 2'b00;
    sel_ep6    = fx2.fx2_fifoadr == 2'b10;
    any_strobe = !fx2.fx2_slrd_n || !fx2.fx2_slwr_n || !fx2.fx2_pktend_n;
    conflict   = (!fx2.fx2_slrd_n && !fx2.fx2_slwr_n) || (any_strobe && !sel_ep2 && !sel_ep6);
    host_out_ready = ep2_cnt != CW'(DEPTH);
    ep2_push   = host_out_valid && host_out_ready;
    ep2_pop    = !fx2.fx2_slrd_n && sel_ep2 && !conflict && ep2_cnt != '0;
    ep2_under  = !fx2.fx2_slrd_n && sel_ep2 && !conflict && ep2_cnt == '0;
    ep6_occ    = ep6_pend + ep6_comm;
    ep6_free   = CW'(DEPTH) - ep6_occ;
    ep6_wr     = !fx2.fx2_slwr_n && sel_ep6 && !conflict;
    ep6_push   = ep6_wr && ep6_occ != CW'(DEPTH);
    ep6_over   = ep6_wr && ep6_occ == CW'(DEPTH);
    ep6_end    = !fx2.fx2_pktend_n && sel_ep6 && !conflict;
    pend_inc   = ep6_pend + CW'(ep6_push);
    commit_pkt = ep6_push && pend_inc == CW'(PKT_WORDS);
    commit_end = ep6_end && pend_inc != '0;
    commit     = commit_pkt || commit_end;
    host_in_valid = ep6_comm != '0;
    ep6_pop    = host_in_valid && host_in_ready;
    host_in_data  = host_in_valid ? ep6_mem[ep6_rp] : 16'h0;
    host_in_last  = host_in_valid ? ep6_last[ep6_rp] : 1'b0;
    fx2.fx2_fd_out = ep2_cnt != '0 ? ep2_mem[ep2_rp] : 16'h0;
    fx2.fx2_fd_oe  = !fx2.fx2_sloe_n && sel_ep2;
    flags_c = {ep2_cnt != '0, ep2_cnt > CW'(AEMPTY_THRESH),
               ep6_occ != CW'(DEPTH), ep6_free > CW'(AFULL_THRESH)};
  end

  always_ff @(posedge fx2_ifclk) begin
    if (!fx2_rst_n) begin
      ep2_wp  <= '0;
      ep2_rp  <= '0;
      ep2_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) ep2_mem[i] <= '0;
    end else begin
      if (ep2_push) ep2_mem[ep2_wp] <= host_out_data;
      ep2_wp  <= ep2_wp + AW'(ep2_push);
      ep2_rp  <= ep2_rp + AW'(ep2_pop);
      ep2_cnt <= ep2_cnt + CW'(ep2_push) - CW'(ep2_pop);
    end
  end

  // A pktend without a concurrent write tags the newest pending word, which sits just behind the write pointer.
  always_ff @(posedge fx2_ifclk) begin
    if (!fx2_rst_n) begin
      ep6_wp   <= '0;
      ep6_rp   <= '0;
      ep6_pend <= '0;
      ep6_comm <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ep6_mem[i]  <= '0;
        ep6_last[i] <= 1'b0;
      end
    end else begin
      if (ep6_push) begin
        ep6_mem[ep6_wp]  <= fx2.fx2_fd_in;
        ep6_last[ep6_wp] <= commit;
      end else if (commit_end) begin
        ep6_last[ep6_wp - AW'(1)] <= 1'b1;
      end
      ep6_wp   <= ep6_wp + AW'(ep6_push);
      ep6_rp   <= ep6_rp + AW'(ep6_pop);
      ep6_pend <= commit ? '0 : pend_inc;
      ep6_comm <= ep6_comm - CW'(ep6_pop) + (commit ? pend_inc : '0);
    end
  end

  always_ff @(posedge fx2_ifclk) begin
    if (!fx2_rst_n) err <= '0;
    else err <= err | {conflict, ep6_over, ep2_under};
  end

`ifdef GLIP_FX2_MODEL_FLAG_DLY_EN
  logic [3:0] flags_q;
  always_ff @(posedge fx2_ifclk) begin
    if (!fx2_rst_n) flags_q <= 4'b0011;
    else flags_q <= flags_c;
  end
  assign {fx2.fx2_flaga_n, fx2.fx2_flagb_n, fx2.fx2_flagc_n, fx2.fx2_flagd_n} = flags_q;
`else
  assign {fx2.fx2_flaga_n, fx2.fx2_flagb_n, fx2.fx2_flagc_n, fx2.fx2_flagd_n} = flags_c;
`endif
endmodule

// File: tb/tb_glip_cypressfx2_fx2_model.sv
// tb_glip_cypressfx2_fx2_model: vector-table and directed checks of the FX2 chip model (default 512-deep and an 8-deep instance).
module tb_glip_cypressfx2_fx2_model;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  glip_cypressfx2_fx2_model_if if0 ();
  glip_cypressfx2_fx2_model_if if1 ();

  logic        hov0, hor0, hiv0, hir0, hil0;
  logic [15:0] hod0, hid0;
  logic [2:0]  err0;
  logic        hor1, hiv1, hir1, hil1;
  logic [15:0] hid1;
  logic [2:0]  err1;
  logic        hov1 = 1'b0;
  logic [15:0] hod1 = 16'h0;

  glip_cypressfx2_fx2_model u0 (
    .fx2_ifclk(clk), .fx2_rst_n(rst_n), .fx2(if0),
    .host_out_valid(hov0), .host_out_ready(hor0), .host_out_data(hod0),
    .host_in_valid(hiv0), .host_in_ready(hir0), .host_in_data(hid0), .host_in_last(hil0),
    .err(err0)
  );

  glip_cypressfx2_fx2_model #(.DEPTH(8), .PKT_WORDS(8)) u1 (
    .fx2_ifclk(clk), .fx2_rst_n(rst_n), .fx2(if1),
    .host_out_valid(hov1), .host_out_ready(hor1), .host_out_data(hod1),
    .host_in_valid(hiv1), .host_in_ready(hir1), .host_in_data(hid1), .host_in_last(hil1),
    .err(err1)
  );

  typedef struct {
    logic        hov;
    logic [15:0] hod;
    logic        slrd_n;
    logic        slwr_n;
    logic        pktend_n;
    logic [1:0]  adr;
    logic [15:0] fdi;
    logic        hir;
    logic [41:0] exp;
  } vec_t;

  vec_t vt [32];
  int   nv = 0;
  int   total = 0;
  int   bad = 0;
  logic [15:0] q [$];

  function automatic logic [41:0] e(logic a, logic b, logic c, logic d, logic hor, logic hiv,
                                    logic last, logic [2:0] er, logic [15:0] fd, logic [15:0] hid);
    return {a, b, c, d, hor, hiv, last, er, fd, hid};
  endfunction

  function automatic logic [41:0] obs0();
    return {if0.fx2_flaga_n, if0.fx2_flagb_n, if0.fx2_flagc_n, if0.fx2_flagd_n,
            hor0, hiv0, hil0, err0, if0.fx2_fd_out, hid0};
  endfunction

  task automatic add(logic hov, logic [15:0] hod, logic slrd_n, logic slwr_n, logic pktend_n,
                     logic [1:0] adr, logic [15:0] fdi, logic hir, logic [41:0] exp);
    vt[nv] = '{hov, hod, slrd_n, slwr_n, pktend_n, adr, fdi, hir, exp};
    nv++;
  endtask

  task automatic chk(string nm, logic [47:0] act, logic [47:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic idle0();
    hov0 = 1'b0; hod0 = '0; hir0 = 1'b0;
    if0.fx2_slrd_n = 1'b1; if0.fx2_slwr_n = 1'b1; if0.fx2_pktend_n = 1'b1;
    if0.fx2_sloe_n = 1'b1; if0.fx2_fifoadr = 2'b00; if0.fx2_fd_in = '0;
  endtask

  initial begin
    rst_n = 1'b0; hir1 = 1'b0;
    idle0();
    if1.fx2_slrd_n = 1'b1; if1.fx2_slwr_n = 1'b1; if1.fx2_pktend_n = 1'b1;
    if1.fx2_sloe_n = 1'b1; if1.fx2_fifoadr = 2'b00; if1.fx2_fd_in = '0;

    add(1, 16'h0001, 1, 1, 1, 2'b00, 0, 0, e(1,0,1,1,1,0,0,3'b000,16'h0001,0));
    add(1, 16'h0002, 1, 1, 1, 2'b00, 0, 0, e(1,1,1,1,1,0,0,3'b000,16'h0001,0));
    add(1, 16'h0003, 1, 1, 1, 2'b00, 0, 0, e(1,1,1,1,1,0,0,3'b000,16'h0001,0));
    add(1, 16'h0004, 1, 1, 1, 2'b00, 0, 0, e(1,1,1,1,1,0,0,3'b000,16'h0001,0));
    add(0, 0, 0, 1, 1, 2'b00, 0, 0, e(1,1,1,1,1,0,0,3'b000,16'h0002,0));
    add(0, 0, 0, 1, 1, 2'b00, 0, 0, e(1,1,1,1,1,0,0,3'b000,16'h0003,0));
    add(0, 0, 0, 1, 1, 2'b00, 0, 0, e(1,0,1,1,1,0,0,3'b000,16'h0004,0));
    add(0, 0, 0, 1, 1, 2'b00, 0, 0, e(0,0,1,1,1,0,0,3'b000,16'h0000,0));
    add(0, 0, 1, 0, 1, 2'b10, 16'hA001, 0, e(0,0,1,1,1,0,0,3'b000,0,0));
    add(0, 0, 1, 0, 1, 2'b10, 16'hA002, 0, e(0,0,1,1,1,0,0,3'b000,0,0));
    add(0, 0, 1, 0, 1, 2'b10, 16'hA003, 0, e(0,0,1,1,1,0,0,3'b000,0,0));
    add(0, 0, 1, 1, 0, 2'b10, 0, 0, e(0,0,1,1,1,1,0,3'b000,0,16'hA001));
    add(0, 0, 1, 1, 1, 2'b00, 0, 1, e(0,0,1,1,1,1,0,3'b000,0,16'hA002));
    add(0, 0, 1, 1, 1, 2'b00, 0, 1, e(0,0,1,1,1,1,1,3'b000,0,16'hA003));
    add(0, 0, 1, 1, 1, 2'b00, 0, 1, e(0,0,1,1,1,0,0,3'b000,0,0));
    add(0, 0, 1, 1, 0, 2'b10, 0, 0, e(0,0,1,1,1,0,0,3'b000,0,0));
    add(0, 0, 1, 0, 0, 2'b10, 16'hB001, 0, e(0,0,1,1,1,1,1,3'b000,0,16'hB001));
    add(0, 0, 1, 1, 1, 2'b00, 0, 1, e(0,0,1,1,1,0,0,3'b000,0,0));
    add(0, 0, 0, 1, 1, 2'b00, 0, 0, e(0,0,1,1,1,0,0,3'b001,0,0));
    add(1, 16'hD001, 1, 1, 1, 2'b00, 0, 0, e(1,0,1,1,1,0,0,3'b001,16'hD001,0));
    add(0, 0, 0, 0, 1, 2'b00, 16'hC000, 0, e(1,0,1,1,1,0,0,3'b101,16'hD001,0));
    add(0, 0, 0, 0, 1, 2'b10, 16'hC001, 0, e(1,0,1,1,1,0,0,3'b101,16'hD001,0));
    add(0, 0, 1, 1, 0, 2'b10, 0, 0, e(1,0,1,1,1,0,0,3'b101,16'hD001,0));
    add(0, 0, 1, 0, 1, 2'b01, 16'hC002, 0, e(1,0,1,1,1,0,0,3'b101,16'hD001,0));
    add(0, 0, 1, 1, 0, 2'b10, 0, 0, e(1,0,1,1,1,0,0,3'b101,16'hD001,0));

    repeat (2) @(posedge clk);
    #1;
    chk("reset0", 48'(obs0()), 48'(e(0,0,1,1,1,0,0,3'b000,0,0)));
    chk("reset1", 48'({if1.fx2_flaga_n, if1.fx2_flagb_n, if1.fx2_flagc_n, if1.fx2_flagd_n, hor1, hiv1, hil1, err1}),
        48'({4'b0011, 3'b100, 3'b000}));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < nv; i++) begin
      @(negedge clk);
      hov0 = vt[i].hov; hod0 = vt[i].hod; hir0 = vt[i].hir;
      if0.fx2_slrd_n = vt[i].slrd_n; if0.fx2_slwr_n = vt[i].slwr_n;
      if0.fx2_pktend_n = vt[i].pktend_n; if0.fx2_fifoadr = vt[i].adr; if0.fx2_fd_in = vt[i].fdi;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i), 48'(obs0()), 48'(vt[i].exp));
    end

    // mid-run reset: EP2 holds D001 and err is set
    @(negedge clk);
    idle0();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midreset", 48'(obs0()), 48'(e(0,0,1,1,1,0,0,3'b000,0,0)));
    @(negedge clk);
    rst_n = 1'b1;
    if0.fx2_sloe_n = 1'b0;
    #1;
    chk("oe_ep2", 48'(if0.fx2_fd_oe), 48'(1));
    if0.fx2_fifoadr = 2'b10;
    #1;
    chk("oe_ep6", 48'(if0.fx2_fd_oe), 48'(0));
    idle0();

    // four-full EP2 with concurrent host push and FPGA pop
    q.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      hov0 = 1'b1; hod0 = 16'hE000 + 16'(i);
      q.push_back(hod0);
      @(posedge clk);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      hov0 = 1'b1; hod0 = 16'hE004 + 16'(k);
      if0.fx2_slrd_n = 1'b0;
      #1;
      chk($sformatf("sim_fd%0d", k), 48'(if0.fx2_fd_out), 48'(q[0]));
      @(posedge clk);
      void'(q.pop_front());
      q.push_back(hod0);
    end
    @(negedge clk);
    hov0 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("drain_fd%0d", k), 48'({if0.fx2_flaga_n, if0.fx2_fd_out}), 48'({1'b1, q[0]}));
      @(posedge clk);
      void'(q.pop_front());
      @(negedge clk);
    end
    chk("drain_empty", 48'({if0.fx2_flaga_n, err0}), 48'({1'b0, 3'b000}));
    idle0();

    // full 256-word packet
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if0.fx2_slwr_n = 1'b0; if0.fx2_fifoadr = 2'b10; if0.fx2_fd_in = 16'h0100 + 16'(i);
      @(posedge clk);
      #1;
      if (i >= 254) chk($sformatf("pkt_valid%0d", i), 48'(hiv0), 48'(i == 255));
    end
    @(negedge clk);
    idle0();
    hir0 = 1'b1;
    for (int i = 0; i < 256; i++) begin
      #1;
      chk($sformatf("pkt_rd%0d", i), 48'({hiv0, hil0, hid0}), 48'({1'b1, i == 255, 16'h0100 + 16'(i)}));
      @(posedge clk);
      @(negedge clk);
    end
    hir0 = 1'b0;
    #1;
    chk("pkt_drained", 48'({hiv0, err0}), 48'({1'b0, 3'b000}));

    // 8-deep instance: almost-full, full, overflow
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if1.fx2_slwr_n = 1'b0; if1.fx2_fifoadr = 2'b10; if1.fx2_fd_in = 16'h0200 + 16'(k - 1);
      @(posedge clk);
      #1;
      chk($sformatf("d8_wr%0d", k), 48'({if1.fx2_flagc_n, if1.fx2_flagd_n, hiv1, err1}),
          48'({k < 8, k < 4, k >= 8, (k == 9) ? 3'b010 : 3'b000}));
    end
    @(negedge clk);
    if1.fx2_slwr_n = 1'b1; if1.fx2_fifoadr = 2'b00;
    hir1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("d8_rd%0d", i), 48'({hiv1, hil1, hid1}), 48'({1'b1, i == 7, 16'h0200 + 16'(i)}));
      @(posedge clk);
      @(negedge clk);
    end
    hir1 = 1'b0;
    #1;
    chk("d8_empty", 48'({hiv1, if1.fx2_flagc_n, if1.fx2_flagd_n}), 48'({1'b0, 1'b1, 1'b1}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/glip_cypressfx2_fx2_model.md
Name: glip_cypressfx2_fx2_model

Overview:
- Synthesizable emulator of the Cypress FX2 chip side of the slave-FIFO interface, clocked by the 30 MHz interface clock.
- Accepts sloe/slrd/slwr/pktend/fifoadr strobes from the FPGA-side GLIP FX2 logic. Holds an EP2 OUT buffer (host->FPGA) and an EP6 IN buffer (FPGA->host), and drives flaga_n..flagd_n.
- Exposes host-side streaming ports, so the FX2 toplevel can run in simulation or loopback without silicon.

Parameters:
- DEPTH, 512: words per endpoint buffer; power of two, at least 4.
- PKT_WORDS, 256: IN packet size in words (512-byte USB packet); power of two, at most DEPTH.
- AFULL_THRESH, 4: flagd_n asserts when EP6 free slots <= AFULL_THRESH.
- AEMPTY_THRESH, 1: flagb_n asserts when EP2 occupancy <= AEMPTY_THRESH.

Ports:
- fx2_ifclk  in  1  interface clock; the only clock.
- fx2_rst_n  in  1  synchronous reset, active-low.
- fx2_fd_in  in  16  data driven by the FPGA.
- fx2_fd_out  out  16  data driven by the model.
- fx2_fd_oe  out  1  model drives the FD bus.
- fx2_sloe_n  in  1  output enable, active-low.
- fx2_slrd_n  in  1  read strobe, active-low.
- fx2_slwr_n  in  1  write strobe, active-low.
- fx2_pktend_n  in  1  packet commit, active-low.
- fx2_fifoadr  in  2  endpoint select: 00 = EP2, 10 = EP6.
- fx2_flaga_n  out  1  EP2 empty, active-low.
- fx2_flagb_n  out  1  EP2 almost empty, active-low.
- fx2_flagc_n  out  1  EP6 full, active-low.
- fx2_flagd_n  out  1  EP6 almost full, active-low.
- host_out_valid  in  1  host word available for EP2.
- host_out_ready  out  1  EP2 can accept a word.
- host_out_data  in  16  host word.
- host_in_valid  out  1  committed EP6 word available.
- host_in_ready  in  1  host consumes a word.
- host_in_data  out  16  EP6 head word.
- host_in_last  out  1  head word ends a USB packet.
- err  out  3  sticky errors: [0] read underflow, [1] write overflow, [2] strobe conflict.

Behaviour:
- Reset (fx2_rst_n=0 at a rising edge):
  - clears both buffers, pointers, pending/committed counts and err.
  - Resulting outputs: flaga_n=0, flagb_n=0, flagc_n=1, flagd_n=1, host_out_ready=1, host_in_valid=0, host_in_last=0, fx2_fd_oe=0, fx2_fd_out=0 when EP2 is empty.
  - Reset mid-transfer discards all data, including uncommitted EP6 words. No strobe or host handshake is acted on during reset.
- Flags are combinational from registered counts.
  - A push or pop at edge N is reflected in the flags after edge N.
  - No further latency unless GLIP_FX2_MODEL_FLAG_DLY_EN is defined.
- EP2 (host->FPGA):
  - Host push when host_out_valid & host_out_ready.
  - fx2_fd_out = EP2 head word, combinational, 0 when empty.
  - fx2_fd_oe = !fx2_sloe_n & fifoadr==00.
  - FPGA pop at an edge with slrd_n=0, fifoadr=00 and EP2 non-empty; the FPGA samples head data at the same edge.
  - slrd_n=0 on empty EP2: no pop, err[0] set.
  - Simultaneous host push and FPGA pop: allowed; occupancy unchanged. When full, the pop frees a slot only for the next cycle.
- EP6 (FPGA->host):
  - Write at an edge with slwr_n=0, fifoadr=10: fx2_fd_in is pushed and the pending count increments.
  - Write while full: word dropped, err[1] set.
  - When pending reaches PKT_WORDS, that word's last bit is set and the pending words become committed.
  - pktend_n=0 with fifoadr=10 and pending>0 sets last on the newest pending word and commits it.
  - pktend in the same cycle as a write commits including the new word, which carries last=1.
  - pktend with pending=0 is ignored (no ZLP).
  - host_in_valid = committed count > 0; host_in_data and host_in_last show the head word.
  - Pop when host_in_valid & host_in_ready.
  - Simultaneous FPGA push, commit and host pop are all allowed in one cycle.
- EP6 full = occupancy==DEPTH, counting committed plus pending words.
- Strobe conflict:
  - slrd_n=0 and slwr_n=0 together, or any strobe with fifoadr not in {00,10}, sets err[2].
  - A conflicting cycle performs neither a pop nor a push.
- Pointers wrap modulo DEPTH. Counts are $clog2(DEPTH+1) bits wide and never exceed DEPTH.
- err bits are cleared only by reset.

Optional Feature:
- GLIP_FX2_MODEL_FLAG_DLY_EN defined: all four flags pass through one extra register stage, so they lag the buffer state by one cycle, as on real FX2 silicon.
  - The overflow/underflow checks still use the true state, so late flag deassertion can set err[0] or err[1].
  - Reset value of the delay registers equals the post-reset flag values.
- Macro undefined: flags are combinational from counts as specified above.

Test Plan:
- Host pushes 0x0001..0x0004; FPGA reads 4 cycles with slrd_n=0, fifoadr=00 -> fd_out=0x0001..0x0004 sampled in order; flaga_n=0 after the 4th edge; err=000.
- FPGA writes 256 words 0x0100..0x01FF to EP6 -> host_in_valid rises after the 256th edge; host reads 256 words with host_in_last=1 only on 0x01FF.
- FPGA writes 3 words, then pktend_n=0 with fifoadr=10 -> 3 words delivered, last=1 on the 3rd; a later pktend with pending=0 produces no host_in_valid.
- DEPTH=8, host_in_ready=0, FPGA writes 9 words -> flagd_n=0 at free<=4, flagc_n=0 after the 8th, 9th word dropped, err[1]=1.
- slrd_n=0 with EP2 empty -> err[0]=1; slrd_n=0 and slwr_n=0 together -> err[2]=1 and no count change; fx2_rst_n=0 one cycle -> err=000 and both buffers empty.
- Simultaneous host push and FPGA pop on a 4-full EP2 over 10 cycles -> occupancy stays 4 and data order is preserved.
